mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, and the per-class execute, memory and writeback steps. It drives every mux select and write enable, including the ALU B-operand select that routes the sign/zero-extended 16-bit immediate. It also decodes `funct` into the 3-bit ALU control.

## Interface
Parameters: none; opcode and funct encodings are fixed below.

Ports (clock and reset first):
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- op  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register load
- regdst  out  1  destination register: 0 = rt, 1 = rd
- memtoreg  out  1  writeback source: 0 = ALUOut, 1 = memory data
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = extended imm, 11 = sign-ext imm << 2
- immsel  out  1  extender mode: 0 = sign-extend, 1 = zero-extend
- pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC load, = pcwrite | (branch & zero)
- alucontrol  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- state  out  4  current state encoding (debug/verification)

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, andi 001100, ori 001101, j 000010.
- Funct decode (R-type only): add 100000→010, sub 100010→110, and 100100→000, or 100101→001, slt 101010→111. Any other funct→010.
- Moore FSM; outputs depend on state only, except pcen (zero) and alucontrol/immsel in EXECUTE and IMMEX (op/funct). Outputs not listed for a state are 0.
  - 0 FETCH: alusrcb=01, alucontrol=010, irwrite=1, pcwrite=1 → DECODE
  - 1 DECODE: alusrcb=11, alucontrol=010. Transitions by op:
    - lw/sw→MEMADR
    - R→EXECUTE
    - beq→BRANCH
    - addi/andi/ori→IMMEX
    - j→JUMP
    - any other op→FETCH (treated as nop)
  - 2 MEMADR: alusrca=1, alusrcb=10, alucontrol=010, immsel=0 → MEMRD if lw, MEMWR if sw
  - 3 MEMRD: iord=1 → MEMWB
  - 4 MEMWB: memtoreg=1, regwrite=1, regdst=0 → FETCH
  - 5 MEMWR: iord=1, memwrite=1 → FETCH
  - 6 EXECUTE: alusrca=1, alusrcb=00, alucontrol=funct decode → ALUWB
  - 7 ALUWB: regdst=1, regwrite=1 → FETCH
  - 8 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1 → FETCH
  - 9 IMMEX: alusrca=1, alusrcb=10. alucontrol: addi 010, andi 000, ori 001. immsel=1 for andi/ori, 0 for addi → IMMWB
  - 10 IMMWB: regdst=0, memtoreg=0, regwrite=1 → FETCH
  - 11 JUMP: pcsrc=10, pcwrite=1 → FETCH
- Encodings 12–15 are illegal. From any illegal encoding, go to FETCH on the next edge; all outputs are 0 while in it.
- op/funct are sampled only in DECODE, EXECUTE and IMMEX. They are guaranteed stable from the cycle after FETCH until the next FETCH.

## Timing
- Reset (synchronous):
  - With reset high at a rising edge, state←FETCH.
  - While reset is high, all outputs are forced 0 combinationally: state output 0, and pcen, irwrite, regwrite, memwrite all 0. No architectural write can occur.
  - The first FETCH with write enables active is the first cycle after reset deasserts.
- Reset mid-instruction aborts it; no partial writeback in the reset cycle.
- Latency in cycles, counted from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3, unknown op 2.
- pcen is combinational:
  - In BRANCH, pcen follows zero within the same cycle; the PC loads at the end of BRANCH only if zero=1.
  - pcen is 1 in FETCH and JUMP regardless of zero.
- regwrite and memwrite are asserted for exactly one cycle per instruction. irwrite is asserted for exactly one cycle per FETCH.

## Test plan
- Reset: hold reset 3 cycles with zero=1 → state=0 and all outputs 0. Release → next cycle irwrite=1, pcen=1, alusrcb=01.
- lw sequence: op=100011 → states 0,1,2,3,4,0. memtoreg=1 and regwrite=1 only in state 4. iord=1 only in state 3.
- R-type sub then slt: op=0, funct=100010 → alucontrol=110 in EXECUTE, then state 7 with regdst=1. funct=101010 → 111. funct=111111 → 010.
- beq: op=000100 with zero=0 in BRANCH → pcen=0, alucontrol=110. Repeat with zero=1 → pcen=1, pcsrc=01. Both return to FETCH after 3 cycles.
- Immediates:
  - ori: op=001101 → IMMEX with immsel=1, alucontrol=001, alusrcb=10.
  - addi: op=001000 → immsel=0, alucontrol=010.
  - Both continue to IMMWB with regwrite=1, regdst=0.
- Illegal op and mid-op reset:
  - op=111111 → DECODE→FETCH with no write enables.
  - Assert reset during MEMWR → memwrite=0 that cycle, state=0 next edge.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute
// and drives every datapath select and write enable, plus the 3-bit ALU control.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       immsel,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   pcwrite, branch;
  logic [2:0] funct_alu;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Unlisted funct codes fall back to add so an unknown R-type behaves like add.
  always_comb begin
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_alu = 3'b010;
    endcase
  end

  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    immsel     = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
        case (op)
          OP_LW, OP_SW:               state_d = S_MEMADR;
          OP_RTYPE:                   state_d = S_EXECUTE;
          OP_BEQ:                     state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_IMMEX;
          OP_J:                       state_d = S_JUMP;
          default:                    state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        state_d    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_ANDI: begin alucontrol = 3'b000; immsel = 1'b1; end
          OP_ORI:  begin alucontrol = 3'b001; immsel = 1'b1; end
          default: begin alucontrol = 3'b010; immsel = 1'b0; end
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    pcen = pcwrite | (branch & zero);

    // Reset squashes everything combinationally so an aborted instruction never writes.
    if (reset) begin
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      immsel     = 1'b0;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      pcen       = 1'b0;
    end
  end

  assign state = reset ? 4'd0 : state_q;

endmodule
